// File: rtl/ysyx_22050039_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22050039_ifu -- instruction fetch unit for the RV64 core.
//
// Owns the architectural PC, issues one instruction-memory read at a time
// and hands the fetched instruction plus its PC to decode over a
// valid/ready handshake. PC redirects (jal/jalr) take priority over the
// sequential pc+4 step in every state. A redirect that lands while a read
// is in flight marks that read as stale, and its response is discarded.
//
// Optional build macro:
//   YSYX_22050039_IFU_MISALIGN_CHK_EN -- adds output fetch_fault. A fetch
//   from a PC with pc[1:0] != 0 issues no memory request. Instead a
//   zero instruction is presented to decode with fetch_fault=1.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   imem_req_valid   out  read request valid
//   imem_req_ready   in   memory accepts request
//   imem_req_addr    out  read address (the current PC)
//   imem_resp_valid  in   read data valid, one per accepted request
//   imem_resp_data   in   read data
//   redirect_valid   in   load redirect_pc as next fetch PC
//   redirect_pc      in   redirect target
//   inst_valid       out  inst/inst_pc valid to decode
//   inst_ready       in   decode accepts
//   inst             out  fetched instruction
//   inst_pc          out  PC of inst
//   fetch_fault      out  (macro only) misaligned-fetch marker
//
// All outputs come straight from flops. There is no combinational path
// from any input to any output.
// ----------------------------------------------------------------------------
module ysyx_22050039_ifu #(
    parameter int                XLEN     = 64,
    parameter int                INST_LEN = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [INST_LEN-1:0]  imem_resp_data,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [INST_LEN-1:0]  inst,
    output logic [XLEN-1:0]      inst_pc
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    ,
    output logic                 fetch_fault
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // Sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
        pc_step = pc + XLEN'(3'd4);
    endfunction

`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    // Instruction fetches must be 4-byte aligned.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        pc_misaligned = (pc[1:0] != 2'b00);
    endfunction
`endif

    logic [1:0]          state_r;
    logic [1:0]          state_s;
    logic [XLEN-1:0]     pc_r;
    logic [XLEN-1:0]     pc_s;
    logic                drop_r;
    logic                drop_s;
    logic [INST_LEN-1:0] inst_r;
    logic [INST_LEN-1:0] inst_s;
    logic [XLEN-1:0]     inst_pc_r;
    logic [XLEN-1:0]     inst_pc_s;
    logic                req_valid_r;
    logic                inst_valid_r;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    logic                fault_r;
    logic                fault_s;
`endif

    // Next-state, next-PC and capture logic for the fetch FSM.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        drop_s    = drop_r;
        inst_s    = inst_r;
        inst_pc_s = inst_pc_r;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
        fault_s   = fault_r;
`endif
        case (state_r)
            S_IDLE: begin
                state_s = S_REQ;
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_REQ: begin
                // imem_req_valid is high throughout REQ, so ready alone
                // completes the handshake. A redirect on the accepting edge
                // makes the just-issued read stale.
                if (imem_req_ready) begin
                    state_s = S_WAIT;
                    drop_s  = redirect_valid;
                end else begin
                    state_s = S_REQ;
                end
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_r || redirect_valid) begin
                        state_s = S_REQ;
                        drop_s  = 1'b0;
                    end else begin
                        inst_s    = imem_resp_data;
                        inst_pc_s = pc_r;
                        state_s   = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_OUT: begin
                // A redirect in the same cycle as the handoff still delivers
                // the instruction; only the next PC changes.
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    state_s = S_REQ;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
                    fault_s = 1'b0;
`endif
                end else if (inst_ready) begin
                    pc_s    = pc_step(pc_r);
                    state_s = S_REQ;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
                    fault_s = 1'b0;
`endif
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
        // Any (re)entry into REQ with a misaligned PC bypasses memory and
        // presents a faulting zero instruction to decode instead.
        if ((state_s == S_REQ) && pc_misaligned(pc_s)) begin
            state_s   = S_OUT;
            inst_s    = {INST_LEN{1'b0}};
            inst_pc_s = pc_s;
            fault_s   = 1'b1;
        end else begin
            fault_s   = fault_s;
        end
`endif
    end

    // FSM state, PC, stale-response flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            inst_r       <= {INST_LEN{1'b0}};
            inst_pc_r    <= RESET_PC;
            req_valid_r  <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            drop_r       <= drop_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            req_valid_r  <= (state_s == S_REQ);
            inst_valid_r <= (state_s == S_OUT);
        end
    end

`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    // Misaligned-fetch marker, tied to the OUT entry that raised it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_s;
        end
    end

    assign fetch_fault = fault_r;
`endif

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;

endmodule

// File: doc/ysyx_22050039_ifu.md
Name: ysyx_22050039_ifu

Overview:
Instruction fetch unit for the RV64 core; sits directly upstream of the decode stage.
- Owns the architectural PC and issues one instruction-memory read at a time.
- Hands the fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts PC redirects (jal/jalr, from the decode/execute pc_wen path) and discards stale in-flight fetches.

Parameters:
XLEN, 64, data/address width
INST_LEN, 32, instruction width
RESET_PC, 64'h8000_0000, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  read address
imem_resp_valid  in  1  read data valid (exactly one per accepted request, at least 1 cycle after acceptance)
imem_resp_data  in  INST_LEN  read data
redirect_valid  in  1  load redirect_pc as next fetch PC
redirect_pc  in  XLEN  redirect target
inst_valid  out  1  inst/inst_pc valid to decode
inst_ready  in  1  decode accepts
inst  out  INST_LEN  fetched instruction
inst_pc  out  XLEN  PC of inst

Behaviour:
- Reset (async assert, released on clk): pc=RESET_PC, state=IDLE, drop=0, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- FSM:
  - IDLE: always -> REQ next cycle.
  - REQ: imem_req_valid=1, imem_req_addr=pc, held stable until imem_req_ready=1; on handshake -> WAIT.
  - WAIT: on imem_resp_valid:
    - drop=1: clear drop, -> REQ.
    - drop=0: latch inst=imem_resp_data, inst_pc=pc, -> OUT.
  - OUT: inst_valid=1; inst/inst_pc held stable while inst_ready=0. On inst_valid&inst_ready: pc=pc+4 (mod 2^XLEN, wraps), -> REQ.
- Max one outstanding request. imem_resp_valid outside WAIT is ignored.
- Zero-wait memory timing: REQ at cycle N, response at N+1, inst_valid at N+2, handoff at N+2, next REQ at N+3. Throughput is 1 instruction per 3 cycles.
- Redirect (redirect_valid=1 at a clock edge) has priority over pc+4 in every state; pc<=redirect_pc.
  - IDLE: -> REQ; first fetch uses redirect_pc.
  - REQ, no handshake: stay REQ; imem_req_addr changes to redirect_pc next cycle. Changing the address of an unaccepted request is permitted.
  - REQ, handshake same cycle: -> WAIT with drop=1.
  - WAIT, no resp: drop=1, stay WAIT. With resp in the same cycle: response discarded, -> REQ.
  - OUT: inst_valid deasserts next cycle, -> REQ. If the handshake also fires that cycle, the instruction counts as delivered and pc=redirect_pc, not pc+4.
- Back-to-back redirects: the last one wins. drop is a single bit because only one request is ever outstanding.
- rst asserted mid-operation (incl. WAIT): immediate return to reset values. Any response arriving after reset release while in IDLE/REQ is ignored.

Optional Feature:
Macro YSYX_22050039_IFU_MISALIGN_CHK_EN.
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0).
  - On entry to REQ, if pc[1:0]!=0, no memory request is issued. The FSM goes directly to OUT with inst=32'h0000_0000, inst_pc=pc, fetch_fault=1.
  - fetch_fault is cleared on the OUT handshake or on redirect.
- Undefined: port absent; pc[1:0] is not checked and the address is issued unchanged.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 32'h00000413, 32'h00100073 -> imem_req_addr 8000_0000 then 8000_0004. inst_valid with inst_pc 8000_0000 then 8000_0004, each 3 cycles apart.
- imem_req_ready held 0 for 5 cycles in REQ -> imem_req_valid=1 and addr 8000_0000 stable for all 5 cycles; WAIT entered only after ready=1.
- inst_ready=0 for 4 cycles in OUT -> inst/inst_pc unchanged, no new imem request, pc not advanced.
- Request for 8000_0008 accepted, redirect_valid with redirect_pc=8000_0100 during WAIT, response 32'hDEADBEEF -> response discarded, next request addr 8000_0100, decode never sees DEADBEEF.
- OUT handshake and redirect_valid (8000_0200) in the same cycle -> instruction delivered once; next request addr 8000_0200, not pc+4.
- With YSYX_22050039_IFU_MISALIGN_CHK_EN, redirect_pc=8000_0102 -> no imem_req_valid; inst_valid=1, inst=0, inst_pc=8000_0102, fetch_fault=1.
